// File: rtl/truth_table_capture_if.sv
// rtl/truth_table_capture_if.sv - control/status bundle for truth_table_capture
// Optional mismatch_cnt member exists only with TRUTH_TABLE_MISMATCH_CNT_EN.
interface truth_table_capture_if;
    logic        start;
    logic [15:0] expected;
    logic [15:0] table_out;
    logic        busy;
    logic        done;
    logic        pass;
`ifdef TRUTH_TABLE_MISMATCH_CNT_EN
    logic [4:0]  mismatch_cnt;

    modport master (
        output start, expected,
        input  table_out, busy, done, pass, mismatch_cnt
    );
    modport slave (
        input  start, expected,
        output table_out, busy, done, pass, mismatch_cnt
    );
`else
    modport master (
        output start, expected,
        input  table_out, busy, done, pass
    );
    modport slave (
        input  start, expected,
        output table_out, busy, done, pass
    );
`endif
endinterface

// File: rtl/truth_table_capture.sv
// rtl/truth_table_capture.sv - sweeps a 4-input circuit through all 16 vectors and captures its truth table
// Optional feature macro: TRUTH_TABLE_MISMATCH_CNT_EN adds ctl.mismatch_cnt.
module truth_table_capture #(
    parameter int DWELL = 50
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_capture_if.slave  ctl,
    output logic                  a,
    output logic                  b,
    output logic                  c,
    output logic                  d,
    input  logic                  F
);

    localparam logic [9:0] LAST_COUNT = 10'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  idx;
    logic [9:0]  count;
    logic [15:0] exp_q;
    logic [15:0] table_q;
    logic [3:0]  vec_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;

    logic [15:0] table_next;
    logic        dwell_end;
    logic        sweep_end;

    // Table as it will look once the current vector's sample lands.
    always_comb begin
        table_next      = table_q;
        table_next[idx] = F;
    end

    assign dwell_end = (state == SWEEP) && (count == LAST_COUNT);
    assign sweep_end = dwell_end && (idx == 4'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= 4'd0;
            count   <= 10'd0;
            exp_q   <= 16'h0000;
            table_q <= 16'h0000;
            vec_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (ctl.start) begin
                        state   <= SWEEP;
                        exp_q   <= ctl.expected;
                        idx     <= 4'd0;
                        count   <= 10'd0;
                        table_q <= 16'h0000;
                        pass_q  <= 1'b0;
                        vec_q   <= 4'd0;
                        busy_q  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (dwell_end) begin
                        table_q <= table_next;
                        count   <= 10'd0;
                        if (idx == 4'd15) begin
                            // Result is judged on the completed table, including the bit sampled now.
                            state  <= DONE;
                            idx    <= 4'd0;
                            vec_q  <= 4'd0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= (table_next == exp_q);
                        end else begin
                            idx   <= idx + 4'd1;
                            vec_q <= idx + 4'd1;
                        end
                    end else begin
                        count <= count + 10'd1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    vec_q  <= 4'd0;
                end
            endcase
        end
    end

    assign {a, b, c, d}  = vec_q;
    assign ctl.table_out = table_q;
    assign ctl.busy      = busy_q;
    assign ctl.done      = done_q;
    assign ctl.pass      = pass_q;

`ifdef TRUTH_TABLE_MISMATCH_CNT_EN
    logic [4:0] mism_q;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mism_q <= 5'd0;
        end else if ((state == IDLE) && ctl.start) begin
            mism_q <= 5'd0;
        end else if (sweep_end) begin
            mism_q <= popcount16(table_next ^ exp_q);
        end
    end

    assign ctl.mismatch_cnt = mism_q;
`endif

endmodule

// File: tb/tb_truth_table_capture.sv
// tb/tb_truth_table_capture.sv - randomized scoreboard bench for truth_table_capture
// Build with TRUTH_TABLE_MISMATCH_CNT_EN to also check mismatch_cnt.
module tb_truth_table_capture;

    localparam int DW          = 4;
    localparam int DW2         = 2;
    localparam int SWEEP_EDGES = 16 * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    truth_table_capture_if ctl ();
    truth_table_capture_if ctl2 ();

    logic a, b, c, d, F;
    logic a2, b2, c2, d2;
    logic F2;

    truth_table_capture #(.DWELL(DW)) dut (
        .clk(clk), .rst_n(rst_n), .ctl(ctl),
        .a(a), .b(b), .c(c), .d(d), .F(F)
    );

    truth_table_capture #(.DWELL(DW2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ctl(ctl2),
        .a(a2), .b(b2), .c(c2), .d(d2), .F(F2)
    );

    typedef struct {
        logic [15:0] tbl;
        logic        pass;
        logic [4:0]  mism;
    } result_t;

    result_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    int          m_k      = 0;
    bit          m_active = 1'b0;
    int          f_mode   = 0;
    logic [15:0] f_tt     = 16'h0000;
    logic        tog_bit  = 1'b0;
    logic        tog_ok;

    logic [15:0] last_tbl  = 16'h0000;
    logic        last_pass = 1'b0;
    logic [4:0]  last_mism = 5'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // F source: mode 0 = lookup table on {a,b,c,d}; mode 1 = noise that is forced low on each sampling cycle.
    always_comb tog_ok = !(m_active && ((m_k % DW) == DW - 1));
    always_comb F = (f_mode == 0) ? f_tt[{a, b, c, d}] : (tog_ok & tog_bit);
    always @(negedge clk) tog_bit <= 1'($urandom);
    assign F2 = 1'b1;

    // Reference model: sweep = 16*DW edges after acceptance; DONE occupies the edge after that.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_k      <= 0;
        end else if (m_active) begin
            if (m_k == SWEEP_EDGES) m_active <= 1'b0;
            else                    m_k <= m_k + 1;
        end else if (ctl.start) begin
            result_t r;
            for (int v = 0; v < 16; v++) begin
                r.tbl[v] = (f_mode == 0) ? f_tt[v] : 1'b0;
            end
            r.pass = (r.tbl == ctl.expected);
            r.mism = 5'($countones(r.tbl ^ ctl.expected));
            sb.push_back(r);
            m_active <= 1'b1;
            m_k      <= 0;
        end
    end

    // Monitor: per-cycle outputs against the model, results popped on done.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            last_tbl  = 16'h0000;
            last_pass = 1'b0;
            last_mism = 5'd0;
        end else begin
            chk("vector", {a, b, c, d},
                (m_active && m_k < SWEEP_EDGES) ? 32'(m_k / DW) : 32'd0);
            chk("busy", ctl.busy, (m_active && m_k < SWEEP_EDGES));
            chk("done_timing", ctl.done, (m_active && m_k == SWEEP_EDGES));
            if (ctl.done) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    result_t r;
                    r = sb.pop_front();
                    chk("table_out", ctl.table_out, r.tbl);
                    chk("pass", ctl.pass, r.pass);
`ifdef TRUTH_TABLE_MISMATCH_CNT_EN
                    chk("mismatch_cnt", ctl.mismatch_cnt, r.mism);
`endif
                    last_tbl  = r.tbl;
                    last_pass = r.pass;
                    last_mism = r.mism;
                end
            end
            if (!m_active) begin
                chk("hold_table", ctl.table_out, last_tbl);
                chk("hold_pass", ctl.pass, last_pass);
`ifdef TRUTH_TABLE_MISMATCH_CNT_EN
                chk("hold_mismatch", ctl.mismatch_cnt, last_mism);
`endif
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_abcd"}, {a, b, c, d}, 0);
        chk({tag, "_busy"}, ctl.busy, 0);
        chk({tag, "_done"}, ctl.done, 0);
        chk({tag, "_pass"}, ctl.pass, 0);
        chk({tag, "_table"}, ctl.table_out, 0);
`ifdef TRUTH_TABLE_MISMATCH_CNT_EN
        chk({tag, "_mism"}, ctl.mismatch_cnt, 0);
`endif
    endtask

    task automatic run_sweep(input int mode, input logic [15:0] tt, input logic [15:0] exp_v,
                             input int restart_k, input int reset_k);
        int guard;
        @(negedge clk);
        f_mode       = mode;
        f_tt         = tt;
        ctl.start    = 1'b1;
        ctl.expected = exp_v;
        @(negedge clk);
        ctl.start = 1'b0;
        guard = 0;
        while (m_active && guard < 200) begin
            ctl.start    = (m_k == restart_k);
            ctl.expected = 16'($urandom);
            if (m_k == reset_k) begin
                ctl.start = 1'b0;
                rst_n = 1'b0;
                #1;
                check_all_zero("async_reset");
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
            @(negedge clk);
            guard++;
        end
        ctl.start = 1'b0;
        if (guard >= 200) chk("sweep_timeout", guard, 0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    initial begin
        logic [15:0] tt;
        int n;
        ctl.start     = 1'b0;
        ctl.expected  = 16'h0000;
        ctl2.start    = 1'b0;
        ctl2.expected = 16'h0000;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(0, 16'hF000, 16'hF000, -1, -1);
        run_sweep(0, 16'h6996, 16'h6996, -1, -1);
        run_sweep(0, 16'h6996, 16'h6997, -1, -1);
        run_sweep(1, 16'h0000, 16'($urandom), -1, -1);
        tt = 16'($urandom);
        run_sweep(0, tt, tt, 7 * DW + 1, -1);
        run_sweep(0, 16'($urandom), 16'($urandom), SWEEP_EDGES, -1);
        run_sweep(0, 16'($urandom), 16'($urandom), -1, 9 * DW + 1);
        run_sweep(0, 16'hF000, 16'hF000, -1, -1);
        for (int i = 0; i < 4; i++) begin
            tt = 16'($urandom);
            run_sweep(0, tt, ($urandom_range(0, 1) != 0) ? tt : 16'($urandom), -1, -1);
        end

        // Short-dwell instance: constant-1 response against an all-zero golden table.
        @(negedge clk);
        ctl2.start    = 1'b1;
        ctl2.expected = 16'h0000;
        @(negedge clk);
        ctl2.start = 1'b0;
        n = 0;
        while (!ctl2.done && n < 100) begin
            chk("dw2_busy", ctl2.busy, 1);
            @(negedge clk);
            n++;
        end
        chk("dw2_done_latency", n, 16 * DW2);
        chk("dw2_table", ctl2.table_out, 16'hFFFF);
        chk("dw2_pass", ctl2.pass, 0);
        chk("dw2_abcd", {a2, b2, c2, d2}, 0);
`ifdef TRUTH_TABLE_MISMATCH_CNT_EN
        chk("dw2_mism", ctl2.mismatch_cnt, 16);
`endif
        @(negedge clk);
        chk("dw2_done_pulse", ctl2.done, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
